// File: rtl/regfile_mp.sv
// regfile_mp: parametrised NRD-read / NWR-write register file with optional bypass and busy scoreboard
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        busy_rd,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_idx,
  output logic [NREG-1:0]       busy_vec
);
  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [DATA_W-1:0] w_regs_nxt [NREG];
  logic [NREG-1:0]   w_busy_nxt;
  logic [NWR-1:0]    w_we_eff;
  logic              w_sb_eff;
  // writes and marks aimed at a hardwired-zero register 0 are simply dropped
  for (genvar j = 0; j < NWR; j++) begin : g_we
    assign w_we_eff[j] = we[j] && !(ZERO_REG != 0 && wa[j*AW +: AW] == '0);
  end
  assign w_sb_eff = sb_set && !(ZERO_REG != 0 && sb_idx == '0);
  // ascending port order makes the highest-index port win on collisions; set is applied last so it beats clear
  always_comb begin
    w_regs_nxt = r_regs;
    w_busy_nxt = r_busy;
    for (int k = 0; k < NWR; k++) begin
      if (w_we_eff[k]) begin
        w_regs_nxt[wa[k*AW +: AW]] = wd[k*DATA_W +: DATA_W];
        w_busy_nxt[wa[k*AW +: AW]] = 1'b0;
      end
    end
    if (w_sb_eff) w_busy_nxt[sb_idx] = 1'b1;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_regs <= '{default: '0};
      r_busy <= '0;
    end else begin
      r_regs <= w_regs_nxt;
      r_busy <= w_busy_nxt;
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]     w_a;
    logic [DATA_W-1:0] w_d;
    logic              w_hit;
    assign w_a = ra[i*AW +: AW];
    always_comb begin
      w_d   = r_regs[w_a];
      w_hit = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        if (BYPASS != 0 && w_we_eff[k] && wa[k*AW +: AW] == w_a) begin
          w_d   = wd[k*DATA_W +: DATA_W];
          w_hit = 1'b1;
        end
      end
    end
    assign rd[i*DATA_W +: DATA_W] = w_d;
    assign busy_rd[i]             = r_busy[w_a] & ~w_hit;
  end
  assign busy_vec = r_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp, bypass and registered-only builds side by side
module tb_regfile_mp;
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [19:0]   ra = '0;
  logic [1:0]    we = '0;
  logic [9:0]    wa = '0;
  logic [63:0]   wd = '0;
  logic          sb_set = 1'b0;
  logic [4:0]    sb_idx = '0;
  logic [127:0]  rd_b, rd_n;
  logic [3:0]    brd_b, brd_n;
  logic [31:0]   bv_b, bv_n;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .resetn(resetn), .ra(ra), .rd(rd_b), .busy_rd(brd_b), .we(we), .wa(wa), .wd(wd),
    .sb_set(sb_set), .sb_idx(sb_idx), .busy_vec(bv_b));
  regfile_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .resetn(resetn), .ra(ra), .rd(rd_n), .busy_rd(brd_n), .we(we), .wa(wa), .wd(wd),
    .sb_set(sb_set), .sb_idx(sb_idx), .busy_vec(bv_n));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    we = '0; wa = '0; wd = '0; sb_set = 1'b0; sb_idx = '0;
  endtask
  task automatic wport(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1; wa[p*5 +: 5] = a; wd[p*32 +: 32] = d;
  endtask
  task automatic setra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    ra = {a3, a2, a1, a0};
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (rd_b !== '0) begin n_err++; $display("FAIL reset_rd got %h want 0", rd_b); end
    n_vec++; if (bv_b !== '0) begin n_err++; $display("FAIL reset_busy got %h want 0", bv_b); end
    #2 resetn = 1'b1;
    idle(); wport(0, 5'd5, 32'hDEADBEEF); sb_set = 1'b1; sb_idx = 5'd7; setra(5, 0, 0, 0);
    tick(); idle(); #1;
    n_vec++; if (rd_n[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_reset_r5 got %h want deadbeef", rd_n[31:0]); end
    n_vec++; if (bv_n !== 32'h80) begin n_err++; $display("FAIL pre_reset_busy got %h want 00000080", bv_n); end
    #2 resetn = 1'b0; #1;
    n_vec++; if (rd_b[31:0] !== 32'h0) begin n_err++; $display("FAIL async_reset_r5 got %h want 0", rd_b[31:0]); end
    n_vec++; if (bv_b !== 32'h0) begin n_err++; $display("FAIL async_reset_busy got %h want 0", bv_b); end
    n_vec++; if (bv_n !== 32'h0) begin n_err++; $display("FAIL async_reset_busy_nb got %h want 0", bv_n); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    idle(); wport(0, 5'd3, 32'h11111111); wport(1, 5'd9, 32'h22222222); setra(3, 9, 0, 4); #1;
    n_vec++; if (rd_b[63:0] !== 64'h22222222_11111111) begin n_err++; $display("FAIL basic_bypass got %h want 2222222211111111", rd_b[63:0]); end
    n_vec++; if (rd_n[63:0] !== 64'h0) begin n_err++; $display("FAIL basic_nobypass got %h want 0", rd_n[63:0]); end
    tick(); idle(); #1;
    n_vec++; if (rd_b !== {32'h0, 32'h0, 32'h22222222, 32'h11111111}) begin n_err++; $display("FAIL basic_read got %h want 0/0/22222222/11111111", rd_b); end
    n_vec++; if (rd_n !== {32'h0, 32'h0, 32'h22222222, 32'h11111111}) begin n_err++; $display("FAIL basic_read_nb got %h want 0/0/22222222/11111111", rd_n); end
  endtask

  task automatic test_collision();
    idle(); wport(0, 5'd12, 32'hAAAA0000); wport(1, 5'd12, 32'h5555FFFF); setra(12, 12, 3, 3); #1;
    n_vec++; if (rd_b[31:0] !== 32'h5555FFFF) begin n_err++; $display("FAIL coll_bypass got %h want 5555ffff", rd_b[31:0]); end
    n_vec++; if (rd_n[31:0] !== 32'h0) begin n_err++; $display("FAIL coll_nobypass got %h want 0", rd_n[31:0]); end
    tick(); idle(); #1;
    n_vec++; if (rd_b[31:0] !== 32'h5555FFFF) begin n_err++; $display("FAIL coll_commit got %h want 5555ffff", rd_b[31:0]); end
    n_vec++; if (rd_n[31:0] !== 32'h5555FFFF) begin n_err++; $display("FAIL coll_commit_nb got %h want 5555ffff", rd_n[31:0]); end
  endtask

  task automatic test_bypass();
    idle(); wport(1, 5'd6, 32'h1); tick();
    idle(); wport(0, 5'd6, 32'h2); setra(6, 0, 0, 0); #1;
    n_vec++; if (rd_b[31:0] !== 32'h2) begin n_err++; $display("FAIL bypass_same got %h want 2", rd_b[31:0]); end
    n_vec++; if (rd_n[31:0] !== 32'h1) begin n_err++; $display("FAIL nobypass_same got %h want 1", rd_n[31:0]); end
    tick(); idle(); #1;
    n_vec++; if (rd_n[31:0] !== 32'h2) begin n_err++; $display("FAIL nobypass_next got %h want 2", rd_n[31:0]); end
  endtask

  task automatic test_scoreboard();
    idle(); sb_set = 1'b1; sb_idx = 5'd8; setra(8, 0, 0, 0); #1;
    n_vec++; if ({brd_b[0], brd_n[0]} !== 2'b00) begin n_err++; $display("FAIL sb_t got %b want 00", {brd_b[0], brd_n[0]}); end
    tick(); idle(); #1;
    n_vec++; if ({brd_b[0], brd_n[0]} !== 2'b11) begin n_err++; $display("FAIL sb_t1 got %b want 11", {brd_b[0], brd_n[0]}); end
    n_vec++; if (bv_b !== 32'h100) begin n_err++; $display("FAIL sb_vec got %h want 00000100", bv_b); end
    tick(); tick();
    wport(0, 5'd8, 32'h88); #1;
    n_vec++; if (brd_b[0] !== 1'b0) begin n_err++; $display("FAIL sb_t3_bypass got %b want 0", brd_b[0]); end
    n_vec++; if (brd_n[0] !== 1'b1) begin n_err++; $display("FAIL sb_t3_nobypass got %b want 1", brd_n[0]); end
    n_vec++; if (bv_b[8] !== 1'b1) begin n_err++; $display("FAIL sb_t3_vec got %b want 1", bv_b[8]); end
    tick(); idle(); #1;
    n_vec++; if ({bv_b[8], bv_n[8], brd_n[0]} !== 3'b000) begin n_err++; $display("FAIL sb_t4 got %b want 000", {bv_b[8], bv_n[8], brd_n[0]}); end
    sb_set = 1'b1; sb_idx = 5'd8; wport(1, 5'd8, 32'h99); tick(); idle(); #1;
    n_vec++; if ({bv_b[8], bv_n[8]} !== 2'b11) begin n_err++; $display("FAIL sb_set_wins got %b want 11", {bv_b[8], bv_n[8]}); end
    n_vec++; if (rd_b[31:0] !== 32'h99) begin n_err++; $display("FAIL sb_write_data got %h want 99", rd_b[31:0]); end
  endtask

  task automatic test_zero();
    idle(); wport(1, 5'd0, 32'hFFFFFFFF); sb_set = 1'b1; sb_idx = 5'd0; setra(0, 0, 0, 0); #1;
    n_vec++; if ({rd_b[31:0], rd_n[31:0]} !== 64'h0) begin n_err++; $display("FAIL zero_same got %h want 0", {rd_b[31:0], rd_n[31:0]}); end
    n_vec++; if ({brd_b[0], brd_n[0], bv_b[0]} !== 3'b000) begin n_err++; $display("FAIL zero_busy_same got %b want 000", {brd_b[0], brd_n[0], bv_b[0]}); end
    tick(); idle(); #1;
    n_vec++; if ({rd_b[31:0], rd_n[31:0]} !== 64'h0) begin n_err++; $display("FAIL zero_next got %h want 0", {rd_b[31:0], rd_n[31:0]}); end
    n_vec++; if ({brd_b[0], brd_n[0], bv_b[0], bv_n[0]} !== 4'b0000) begin n_err++; $display("FAIL zero_busy_next got %b want 0000", {brd_b[0], brd_n[0], bv_b[0], bv_n[0]}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
